port_short_seq: RTL and testbench

//  Multi-channel port-shorting sequencer. It generalises the fixed two-port

---
 rtl/port_short_seq.sv | 131 +++++++++++++
 tb/tb_port_short_seq.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/port_short_seq.sv
// Port-shorting sequencer: ties any subset of NCH ports to one shared node
// through a break / discharge / make / settle sequence with registered switch drives.
module port_short_seq #(
  parameter int NCH     = 4,
  parameter int CNT_W   = 8,
  parameter int BBM_CYC = 2,
  parameter int DIS_CYC = 16,
  parameter int SET_CYC = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [NCH-1:0] req_mask,
  output logic [NCH-1:0] sw_en,
  output logic           gnd_en,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic [NCH-1:0] cur_mask,
  output logic [2:0]     state_dbg
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_BREAK  = 3'd1;
  localparam logic [2:0] ST_DISCH  = 3'd2;
  localparam logic [2:0] ST_MAKE   = 3'd3;
  localparam logic [2:0] ST_SETTLE = 3'd4;

  localparam logic [CNT_W-1:0] BBM_LD = CNT_W'(BBM_CYC - 1);
  localparam logic [CNT_W-1:0] DIS_LD = CNT_W'(DIS_CYC - 1);
  localparam logic [CNT_W-1:0] SET_LD = CNT_W'(SET_CYC - 1);

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [NCH-1:0]   lat_mask;
  logic             accept;
  logic             single_bit;
  logic             cnt_zero;

  // Handshake: a request transfers on a rising edge where req_valid and
  // req_ready are both high; req_ready is high only in IDLE, so anything
  // presented while busy is simply not taken and never queued.
  assign req_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign state_dbg = state;
  assign accept    = req_valid & req_ready;
  assign cnt_zero  = (cnt == '0);

  // Exactly one bit set would short a port only to itself.
  assign single_bit = (req_mask != '0) &&
                      ((req_mask & (req_mask - NCH'(1))) == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      lat_mask <= '0;
      sw_en    <= '0;
      gnd_en   <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      cur_mask <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (single_bit) begin
              err <= 1'b1;
            end else if (req_mask == cur_mask) begin
              done <= 1'b1;
            end else begin
              lat_mask <= req_mask;
              sw_en    <= '0;
              cnt      <= BBM_LD;
              state    <= ST_BREAK;
            end
          end
        end
        ST_BREAK: begin
          if (cnt_zero) begin
            gnd_en <= 1'b1;
            cnt    <= DIS_LD;
            state  <= ST_DISCH;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_DISCH: begin
          if (cnt_zero) begin
            gnd_en <= 1'b0;
            // An all-open request ends here: nothing to make or settle.
            if (lat_mask == '0) begin
              cur_mask <= '0;
              done     <= 1'b1;
              state    <= ST_IDLE;
            end else begin
              state <= ST_MAKE;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_MAKE: begin
          // gnd_en already dropped on entry, so closing switches here keeps
          // one dead cycle between discharge and make.
          sw_en    <= lat_mask;
          cur_mask <= lat_mask;
          cnt      <= SET_LD;
          state    <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (cnt_zero) begin
            done  <= 1'b1;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          sw_en  <= '0;
          gnd_en <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_port_short_seq.sv
// Bench for port_short_seq: directed scenarios plus random traffic against a
// phase-timeline reference model; a second instance runs with NCH=8.
module tb_port_short_seq;

  localparam int NCH     = 4;
  localparam int BBM     = 2;
  localparam int DIS     = 16;
  localparam int SET     = 16;
  localparam int T_MAKE  = BBM + DIS;
  localparam int T_DONE  = BBM + DIS + 1 + SET;
  localparam int T_DONE0 = BBM + DIS;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic           req_valid, req_ready, gnd_en, busy, done, err;
  logic [NCH-1:0] req_mask, sw_en, cur_mask;
  logic [2:0]     state_dbg;

  logic       rv8, ready8, gnd8, busy8, done8, err8;
  logic [7:0] rm8, sw8, cur8;
  logic [2:0] state8;

  port_short_seq #(.NCH(NCH), .CNT_W(8), .BBM_CYC(BBM), .DIS_CYC(DIS), .SET_CYC(SET)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_mask(req_mask), .sw_en(sw_en), .gnd_en(gnd_en), .busy(busy),
    .done(done), .err(err), .cur_mask(cur_mask), .state_dbg(state_dbg)
  );

  port_short_seq #(.NCH(8), .CNT_W(8), .BBM_CYC(BBM), .DIS_CYC(DIS), .SET_CYC(SET)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv8), .req_ready(ready8),
    .req_mask(rm8), .sw_en(sw8), .gnd_en(gnd8), .busy(busy8),
    .done(done8), .err(err8), .cur_mask(cur8), .state_dbg(state8)
  );

  // scoreboard counters
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Reference timeline: k = cycles elapsed since the accepting edge.
  function automatic void phase(input int k, input logic nz, output logic sw_on,
                                output logic gnd, output logic bsy, output logic dn);
    int t_end;
    t_end = nz ? T_DONE : T_DONE0;
    gnd   = (k >= BBM) && (k < BBM + DIS);
    sw_on = nz && (k > T_MAKE);
    bsy   = (k < t_end);
    dn    = (k == t_end);
  endfunction

  logic           m_active;
  int             m_k;
  logic [NCH-1:0] m_lat, m_cur;
  logic [NCH-1:0] e_sw, e_cur;
  logic           e_gnd, e_busy, e_done, e_err;
  logic           p_sw, p_g, p_b, p_d;

  // driver: apply inputs at negedge, advance model at posedge, check at next negedge
  task automatic step(input logic v, input logic [NCH-1:0] m);
    logic sw_on, g, b, d;
    req_valid = v;
    req_mask  = m;
    @(posedge clk);
    e_done = 1'b0;
    e_err  = 1'b0;
    if (m_active) m_k++;
    else if (v) begin
      if ($countones(m) == 1) e_err = 1'b1;
      else if (m == m_cur) e_done = 1'b1;
      else begin
        m_active = 1'b1;
        m_k      = 0;
        m_lat    = m;
      end
    end
    if (m_active) begin
      phase(m_k, m_lat != '0, sw_on, g, b, d);
      e_gnd  = g;
      e_busy = b;
      e_done = d;
      e_sw   = sw_on ? m_lat : '0;
      e_cur  = sw_on ? m_lat : m_cur;
      if (d) begin
        m_active = 1'b0;
        m_cur    = m_lat;
        e_cur    = m_lat;
      end
    end else begin
      e_gnd  = 1'b0;
      e_busy = 1'b0;
      e_sw   = m_cur;
      e_cur  = m_cur;
    end
    @(negedge clk);
    check_eq("sw_en", sw_en, e_sw);
    check_eq("gnd_en", gnd_en, e_gnd);
    check_eq("busy", busy, e_busy);
    check_eq("req_ready", req_ready, !e_busy);
    check_eq("done", done, e_done);
    check_eq("err", err, e_err);
    check_eq("cur_mask", cur_mask, e_cur);
    check_eq("bbm4", gnd_en && (sw_en != '0), 1'b0);
    check_eq("bbm8", gnd8 && (sw8 != '0), 1'b0);
  endtask

  int             sw_first, done_at;
  logic [NCH-1:0] rmask;

  initial begin
    req_valid = 1'b0;
    req_mask  = '0;
    rv8       = 1'b0;
    rm8       = '0;
    m_active  = 1'b0;
    m_k       = 0;
    m_lat     = '0;
    m_cur     = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // reset state
    check_eq("rst_sw", sw_en, 0);
    check_eq("rst_gnd", gnd_en, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_cur", cur_mask, 0);
    check_eq("rst_ready", req_ready, 1);
    check_eq("rst_ready8", ready8, 1);

    // full sequence to 0011; requests during busy must be dropped
    sw_first = -1;
    done_at  = -1;
    for (int i = 0; i < 40; i++) begin
      step(i < 10, (i == 0) ? 4'b0011 : 4'($urandom));
      if (sw_en == 4'b0011 && sw_first < 0) sw_first = i;
      if (done && done_at < 0) done_at = i;
    end
    check_eq("s1_sw_at", sw_first, T_MAKE + 1);
    check_eq("s1_done_at", done_at, T_DONE);
    check_eq("s1_cur", cur_mask, 4'b0011);

    // single-bit mask rejected
    step(1'b1, 4'b0100);
    check_eq("s2_err", err, 1);
    check_eq("s2_busy", busy, 0);
    check_eq("s2_sw", sw_en, 4'b0011);
    step(1'b0, '0);

    // same mask again: immediate done, no switching
    step(1'b1, 4'b0011);
    check_eq("s3_done", done, 1);
    check_eq("s3_busy", busy, 0);
    check_eq("s3_sw", sw_en, 4'b0011);
    step(1'b0, '0);

    // open-all request: no MAKE, done right after discharge
    done_at = -1;
    for (int i = 0; i < 25; i++) begin
      step(i == 0, '0);
      if (done && done_at < 0) done_at = i;
    end
    check_eq("s4_done_at", done_at, T_DONE0);
    check_eq("s4_cur", cur_mask, 0);

    // async reset during settle
    step(1'b1, 4'b0101);
    repeat (24) step(1'b0, '0);
    check_eq("s5_pre_sw", sw_en, 4'b0101);
    #2 rst_n = 1'b0;
    #1;
    check_eq("s5_sw", sw_en, 0);
    check_eq("s5_gnd", gnd_en, 0);
    check_eq("s5_busy", busy, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n    = 1'b1;
    m_active = 1'b0;
    m_cur    = '0;
    check_eq("s5_ready", req_ready, 1);
    check_eq("s5_cur", cur_mask, 0);

    // NCH=8 instance, mask C1
    rv8 = 1'b1;
    rm8 = 8'hC1;
    for (int k = 0; k <= T_DONE + 2; k++) begin
      step(1'b0, '0);
      rv8 = 1'b0;
      phase(k, 1'b1, p_sw, p_g, p_b, p_d);
      check_eq("n8_sw", sw8, p_sw ? 8'hC1 : 8'h00);
      check_eq("n8_gnd", gnd8, p_g);
      check_eq("n8_busy", busy8, p_b);
      check_eq("n8_done", done8, p_d);
    end
    check_eq("n8_cur", cur8, 8'hC1);

    // random traffic
    for (int i = 0; i < 800; i++) begin
      case ($urandom_range(0, 3))
        0:       rmask = 4'($urandom);
        1:       rmask = 4'(1 << $urandom_range(0, 3));
        2:       rmask = m_cur;
        default: rmask = '0;
      endcase
      step($urandom_range(0, 2) == 0, rmask);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
